// File: rtl/module_stereo_adc_input_pkg.sv
// Types, constants and output scaling shared by the stereo ADC front end
// and its per-channel CIC decimator.
`include "globals.vh"

package module_stereo_adc_input_pkg;

  localparam int CIC_WIDTH = `CIC_WIDTH;
  localparam int CIC_RATIO = `CIC_RATIO;
  localparam int CIC_ORDER = `CIC_ORDER;
  localparam int OUT_WIDTH = 18;
  localparam int PHASE_W   = $clog2(CIC_RATIO);

  typedef logic signed [CIC_WIDTH-1:0] cic_t;
  typedef logic signed [OUT_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_C1,
    ST_C2,
    ST_C3,
    ST_OUT
  } comb_state_t;

  // Full-scale CIC output (+32768) would land one LSB above the 18-bit
  // positive limit after the x4 scale, so it is clamped.
  function automatic sample_t scale_sat(input cic_t c);
    logic signed [OUT_WIDTH:0] wide;
    wide = {c, 2'b00};
    if (wide > 19'sd131071)
      return 18'sd131071;
    else if (wide < -19'sd131072)
      return -18'sd131072;
    return wide[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/cic3_decim32.sv
// One channel of the 3rd-order, R=32, M=1 CIC decimator: bit-to-+/-1
// mapping, tick-enabled integrator chain and FSM-sequenced comb datapath.
module cic3_decim32
  import module_stereo_adc_input_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        din,
  input  comb_state_t state,
  output cic_t        c3
);

  localparam cic_t X_POS = cic_t'(1);
  localparam cic_t X_NEG = cic_t'(-1);

  cic_t x;
  cic_t i1, i2, i3;
  cic_t d1, d2, d3;
  cic_t c1, c2;

  assign x = din ? X_POS : X_NEG;

  // Two's-complement wrap is intentional: the comb differences recover the
  // exact result as long as the register width covers the CIC bit growth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the previous
      // cycle's value, giving the registered integrator chain.
      if (tick) begin
        i1 <= i1 + x;
        i2 <= i2 + i1;
        i3 <= i3 + i2;
      end
      // I3 only moves on tick edges, and the next tick is at least two clks
      // after the decimation event, so C1 sees the value from the event.
      unique case (state)
        ST_C1: begin
          c1 <= i3 - d1;
          d1 <= i3;
        end
        ST_C2: begin
          c2 <= c1 - d2;
          d2 <= c1;
        end
        ST_C3: begin
          c3 <= c2 - d3;
          d3 <= c2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/globals.vh
// Project-wide constants shared by the stereo ADC front end.
// Include-guarded so several compilation units may pull it in.
`ifndef GLOBALS_VH
`define GLOBALS_VH

// 98.304 MHz system clock / 64 = 1.536 MHz modulator tick.
`define CLK_DIV_1536K 64
`define CIC_WIDTH     17
`define CIC_RATIO     32
`define CIC_ORDER     3

`endif

// File: rtl/module_stereo_adc_input.sv
// Stereo sigma-delta ADC front end: input synchronizers, 1.536 MHz tick,
// feedback registers, shared comb FSM and warm-up gating of 48 kHz samples.
`include "globals.vh"

module module_stereo_adc_input
  import module_stereo_adc_input_pkg::*;
#(
  parameter int CLK_DIV        = `CLK_DIV_1536K,
  parameter int WARMUP_SAMPLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_in_l,
  input  logic                 adc_in_r,
  output logic                 adc_fb_l,
  output logic                 adc_fb_r,
  output logic                 sample_out_rdy,
  output logic signed [17:0]   sample_out_l,
  output logic signed [17:0]   sample_out_r
);

  localparam logic [6:0]         TICK_LAST  = 7'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CIC_RATIO - 1);
  localparam logic [1:0]         WARM_LIMIT = 2'(WARMUP_SAMPLES);

  logic [1:0]         sync_l, sync_r;
  logic [6:0]         tick_cnt;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic               dec_event;
  logic [1:0]         warm_cnt;
  comb_state_t        state_q, state_d;
  cic_t               c3_l, c3_r;

  assign tick      = (tick_cnt == TICK_LAST);
  assign dec_event = tick && (phase == PHASE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_l   <= '0;
      sync_r   <= '0;
      tick_cnt <= '0;
      phase    <= '0;
      adc_fb_l <= 1'b0;
      adc_fb_r <= 1'b0;
    end else begin
      sync_l   <= {sync_l[0], adc_in_l};
      sync_r   <= {sync_r[0], adc_in_r};
      tick_cnt <= tick ? '0 : tick_cnt + 7'd1;
      if (tick) begin
        phase    <= phase + 1'b1;
        adc_fb_l <= sync_l[1];
        adc_fb_r <= sync_r[1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning the default first keeps this block free of latches.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (dec_event) state_d = ST_C1;
      ST_C1:   state_d = ST_C2;
      ST_C2:   state_d = ST_C3;
      ST_C3:   state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Warm-up passes still run the combs so their delays are primed, but the
  // transient results are never published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt       <= '0;
      sample_out_rdy <= 1'b0;
      sample_out_l   <= '0;
      sample_out_r   <= '0;
    end else begin
      sample_out_rdy <= 1'b0;
      if (state_q == ST_OUT) begin
        if (warm_cnt == WARM_LIMIT) begin
          sample_out_rdy <= 1'b1;
          sample_out_l   <= scale_sat(c3_l);
          sample_out_r   <= scale_sat(c3_r);
        end else begin
          warm_cnt <= warm_cnt + 2'd1;
        end
      end
    end
  end

  cic3_decim32 u_cic_l (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .din   (sync_l[1]),
    .state (state_q),
    .c3    (c3_l)
  );

  cic3_decim32 u_cic_r (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .din   (sync_r[1]),
    .state (state_q),
    .c3    (c3_r)
  );

endmodule

// File: tb/tb_module_stereo_adc_input.sv
// Directed bench for module_stereo_adc_input with CLK_DIV=4: one decimation
// event every 128 clks, the first published sample 516 clks after reset.
module tb_module_stereo_adc_input;
  import module_stereo_adc_input_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int FIRST_RDY = 516;
  localparam int PERIOD    = 128;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               adc_in_l = 1'b0;
  logic               adc_in_r = 1'b0;
  logic               adc_fb_l, adc_fb_r;
  logic               sample_out_rdy;
  logic signed [17:0] sample_out_l, sample_out_r;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         manual   = 1'b0;
  logic [3:0] pat_l    = 4'b0000;
  logic [3:0] pat_r    = 4'b0000;

  module_stereo_adc_input #(.CLK_DIV(CLK_DIV), .WARMUP_SAMPLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_in_l       (adc_in_l),
    .adc_in_r       (adc_in_r),
    .adc_fb_l       (adc_fb_l),
    .adc_fb_r       (adc_fb_r),
    .sample_out_rdy (sample_out_rdy),
    .sample_out_l   (sample_out_l),
    .sample_out_r   (sample_out_r)
  );

  always #5 clk = ~clk;

  // Input pattern advances once per CLK_DIV clks, so each tick sees one element.
  task automatic drive_pattern();
    int idx;
    idx = (cyc / CLK_DIV) % 4;
    adc_in_l = pat_l[idx];
    adc_in_r = pat_r[idx];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    if (!manual) drive_pattern();
  endtask

  // One clk: cyc counts posedges since reset release; outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!manual) drive_pattern();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample_out_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %0b expected 0", sample_out_rdy);
    end
    n_checks++;
    if (sample_out_l !== 18'sd0) begin
      n_fail++; $display("FAIL reset_l: got %0d expected 0", sample_out_l);
    end
    n_checks++;
    if (sample_out_r !== 18'sd0) begin
      n_fail++; $display("FAIL reset_r: got %0d expected 0", sample_out_r);
    end
    n_checks++;
    if (adc_fb_l !== 1'b0 || adc_fb_r !== 1'b0) begin
      n_fail++; $display("FAIL reset_fb: got %0b%0b expected 00", adc_fb_l, adc_fb_r);
    end
  endtask

  task automatic test_rdy_period();
    int first, second, n;
    manual = 1'b0; pat_l = 4'b1111; pat_r = 4'b0000;
    do_reset();
    first = -1; second = -1; n = 0;
    while (cyc < FIRST_RDY + PERIOD + 8) begin
      step();
      if (cyc == FIRST_RDY - 1) begin
        n_checks++;
        if (sample_out_l !== 18'sd0) begin
          n_fail++; $display("FAIL warmup_hold_l: got %0d expected 0", sample_out_l);
        end
      end
      if (sample_out_rdy) begin
        n++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    n_checks++;
    if (first != FIRST_RDY) begin
      n_fail++; $display("FAIL first_rdy_cycle: got %0d expected %0d", first, FIRST_RDY);
    end
    n_checks++;
    if (second - first != PERIOD) begin
      n_fail++; $display("FAIL rdy_period: got %0d expected %0d", second - first, PERIOD);
    end
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL rdy_count_period: got %0d expected 2", n);
    end
  endtask

  task automatic test_constant();
    int n;
    manual = 1'b0; pat_l = 4'b1111; pat_r = 4'b0000;
    do_reset();
    n = 0;
    while (cyc < FIRST_RDY + 2 * PERIOD + 8) begin
      step();
      if (sample_out_rdy) begin
        n++;
        n_checks++;
        if (sample_out_l !== 18'sd131071) begin
          n_fail++; $display("FAIL const_l: got %0d expected 131071", sample_out_l);
        end
        n_checks++;
        if (sample_out_r !== -18'sd131072) begin
          n_fail++; $display("FAIL const_r: got %0d expected -131072", sample_out_r);
        end
      end
      if (cyc == FIRST_RDY + PERIOD / 2) begin
        n_checks++;
        if (sample_out_l !== 18'sd131071 || sample_out_rdy !== 1'b0) begin
          n_fail++; $display("FAIL const_hold: got %0d rdy %0b expected 131071 rdy 0",
                             sample_out_l, sample_out_rdy);
        end
      end
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL const_rdy_count: got %0d expected 3", n);
    end
  endtask

  task automatic test_alternating();
    int n;
    manual = 1'b0; pat_l = 4'b0101; pat_r = 4'b1010;
    do_reset();
    n = 0;
    while (cyc < FIRST_RDY + 2 * PERIOD + 8) begin
      step();
      if (sample_out_rdy) begin
        n++;
        n_checks++;
        if (sample_out_l !== 18'sd0 || sample_out_r !== 18'sd0) begin
          n_fail++; $display("FAIL alt_out: got %0d/%0d expected 0/0", sample_out_l, sample_out_r);
        end
      end
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL alt_rdy_count: got %0d expected 3", n);
    end
  endtask

  // Left 3-of-4 ones (mean +0.5), right 1-of-4 ones (mean -0.5).
  task automatic test_three_of_four();
    int n;
    manual = 1'b0; pat_l = 4'b0111; pat_r = 4'b0001;
    do_reset();
    n = 0;
    while (cyc < FIRST_RDY + 2 * PERIOD + 8) begin
      step();
      if (sample_out_rdy) begin
        n++;
        n_checks++;
        if (sample_out_l !== 18'sd65536) begin
          n_fail++; $display("FAIL three4_l: got %0d expected 65536", sample_out_l);
        end
        n_checks++;
        if (sample_out_r !== -18'sd65536) begin
          n_fail++; $display("FAIL one4_r: got %0d expected -65536", sample_out_r);
        end
      end
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL three4_rdy_count: got %0d expected 3", n);
    end
  endtask

  // Fourth event is consumed at edge 512, so the FSM sits in C2 after edge 513.
  task automatic test_reset_mid_fsm();
    int first;
    manual = 1'b0; pat_l = 4'b1111; pat_r = 4'b0000;
    do_reset();
    while (cyc < FIRST_RDY - 3) step();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample_out_rdy !== 1'b0 || sample_out_l !== 18'sd0 || sample_out_r !== 18'sd0) begin
      n_fail++; $display("FAIL midfsm_outputs: got rdy %0b l %0d r %0d expected 0 0 0",
                         sample_out_rdy, sample_out_l, sample_out_r);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL midfsm_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    drive_pattern();
    first = -1;
    while (cyc < FIRST_RDY + 8) begin
      step();
      if (sample_out_rdy && first < 0) first = cyc;
    end
    n_checks++;
    if (first != FIRST_RDY) begin
      n_fail++; $display("FAIL midfsm_first_rdy: got %0d expected %0d", first, FIRST_RDY);
    end
  endtask

  // Input rises after edge 5 and falls after edge 10; ticks are consumed on
  // edges 4, 8, 12, 16, so feedback is high exactly for edges 8..15.
  task automatic test_fb_sync();
    logic exp_fb;
    manual = 1'b1;
    adc_in_l = 1'b0; adc_in_r = 1'b0;
    do_reset();
    while (cyc < 16) begin
      step();
      exp_fb = (cyc >= 8) && (cyc < 16);
      n_checks++;
      if (adc_fb_l !== exp_fb) begin
        n_fail++; $display("FAIL fb_l_cyc%0d: got %0b expected %0b", cyc, adc_fb_l, exp_fb);
      end
      if (cyc == 5)  adc_in_l = 1'b1;
      if (cyc == 10) adc_in_l = 1'b0;
    end
    n_checks++;
    if (adc_fb_r !== 1'b0) begin
      n_fail++; $display("FAIL fb_r_static: got %0b expected 0", adc_fb_r);
    end
    manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fb_sync();
    test_rdy_period();
    test_constant();
    test_alternating();
    test_three_of_four();
    test_reset_mid_fsm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_stereo_adc_input.md
MODULE_STEREO_ADC_INPUT -- requirements
Module: module_stereo_adc_input

Interface
REQ-001 Parameter: CLK_DIV, default `CLK_DIV_1536K, clk cycles per 1536 kHz modulator tick.
REQ-002 Parameter: WARMUP_SAMPLES, default 3, decimated outputs suppressed after reset.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 adc_in_l  input  1  left comparator bit, asynchronous to clk.
REQ-006 adc_in_r  input  1  right comparator bit, asynchronous to clk.
REQ-007 adc_fb_l  output  1  left modulator feedback bit, registered.
REQ-008 adc_fb_r  output  1  right modulator feedback bit, registered.
REQ-009 sample_out_rdy  output  1  one-clk pulse, new 48 kHz stereo sample valid.
REQ-010 sample_out_l  output  18  signed left sample, held between pulses.
REQ-011 sample_out_r  output  18  signed right sample, held between pulses.

Function
REQ-012 adc_in_l/r SHALL each pass a 2-flop synchronizer before any use.
REQ-013 A 7-bit tick counter SHALL count 0..CLK_DIV-1 and wrap to 0; tick asserts for the one clk where the count equals CLK_DIV-1.
REQ-014 On tick, the synchronized bits SHALL be registered into adc_fb_l/r; the registered bits are held until the next tick.
REQ-015 Each channel SHALL map its bit to x = +1 (bit 1) or -1 (bit 0) as 17-bit signed.
REQ-016 Each channel SHALL run a 3rd-order CIC decimator: R=32, M=1, 17-bit two's-complement registers, wrap on overflow with no saturation.
REQ-017 Integrators SHALL update only on tick, registered chain: I1<=I1+x, I2<=I2+I1, I3<=I3+I2, using previous-cycle values.
REQ-018 A 5-bit phase counter SHALL increment on each tick and wrap 31->0; the decimation event is the tick where the counter wraps.
REQ-019 The comb FSM states SHALL be IDLE, C1, C2, C3, OUT: IDLE->C1 on the clk after the decimation event; C1->C2->C3->OUT->IDLE unconditionally, one clk each.
REQ-020 In C1, the FSM SHALL compute c1=I3-D1 and set D1<=I3 (I3 latched at the event). In C2 it SHALL compute c2=c1-D2 and set D2<=c1. In C3 it SHALL compute c3=c2-D3 and set D3<=c2.
REQ-021 In OUT, the FSM SHALL set sample_out = c3 shifted left 2 into 18 bits; +131072 saturates to +131071; -131072 passes unchanged.
REQ-022 sample_out_rdy SHALL pulse for exactly one clk in OUT; the latency from the decimation-event clk to the pulse is 5 clks.
REQ-023 The first WARMUP_SAMPLES OUT passes after reset SHALL update the comb delays but SHALL NOT pulse rdy or change sample_out_l/r; a 2-bit warm-up counter saturates at WARMUP_SAMPLES.
REQ-024 Both channels SHALL share the tick, phase counter, FSM and rdy, so L and R stay sample-aligned.
REQ-025 CLK_DIV SHALL be >= 2; the FSM always returns to IDLE before the next decimation event (32*CLK_DIV clks apart), so no overlap handling is required.
REQ-026 The rdy pulse period SHALL be exactly 32*CLK_DIV clks in steady state.

Reset
REQ-027 Reset SHALL clear synchronizers, all counters, integrators, comb delays, c1..c3, adc_fb_l/r, sample_out_l/r and sample_out_rdy to 0, and set the FSM to IDLE.
REQ-028 Reset asserted mid-FSM SHALL abort the computation; no rdy pulse follows reset deassertion until warm-up completes again.

Structure
REQ-029 CLK_DIV_1536K, CIC_WIDTH=17, CIC_RATIO=32 and CIC_ORDER=3 SHALL reside in globals.vh.
REQ-030 A sub-module cic3_decim32 (integrators, comb datapath, input mapping) SHALL be instantiated once per channel; the top holds the synchronizers, tick and phase counters, FSM, warm-up logic and feedback registers.

Verification
REQ-031 adc_in_l=1 constant, adc_in_r=0 constant -> after warm-up, every rdy shows sample_out_l=+131071 and sample_out_r=-131072.
REQ-032 Alternating 1,0 per tick on both channels -> steady-state sample_out_l/r = 0 on every rdy.
REQ-033 Pattern 3-of-4 ones, repeating -> steady-state output = +65536 ((32768/2)<<2).
REQ-034 Count clks between rdy pulses with CLK_DIV=4 -> exactly 128; no rdy for the first 3 decimation events after reset.
REQ-035 Assert reset while FSM is in C2 -> no rdy pulse, outputs 0, FSM IDLE; after release, the first rdy appears only after the 4th decimation event.
REQ-036 Toggle adc_in_l mid-tick-period -> adc_fb_l changes only on the tick clk, at least 2 clks after the input edge.
